// File: rtl/pong_packer.sv
// Packs consecutive FIFO words into {hi, lo} packets with a zero-padding flush.
// Optional packet counter on out_count is enabled by defining PONG_PACKER_COUNT_EN.
module pong_packer #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned COUNT_W = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [WIDTH-1:0]   in_first,
   input  logic               in_first__RDY,
   input  logic               in_deq__RDY,
   output logic               in_deq__ENA,
   output logic [2*WIDTH-1:0] out_enq_v,
   input  logic               out_enq__RDY,
   output logic               out_enq__ENA,
   input  logic               flush__ENA,
   output logic               flush__RDY
`ifdef PONG_PACKER_COUNT_EN
   ,
   output logic [COUNT_W-1:0] out_count
`endif
);

   typedef enum logic [1:0] {S_LO, S_HI, S_OUT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             up_ok;

   assign up_ok        = in_first__RDY & in_deq__RDY;
   assign in_deq__ENA  = up_ok & ((state_q != S_OUT) | out_enq__RDY);
   assign out_enq__ENA = (state_q == S_OUT) & out_enq__RDY;
   assign out_enq_v    = {hi_q, lo_q};
   // A real word always wins over padding, so flush is withheld while one is available.
   assign flush__RDY   = (state_q == S_HI) & ~up_ok;

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      case (state_q)
         S_LO: begin
            if (in_deq__ENA) begin
               lo_d    = in_first;
               state_d = S_HI;
            end
         end
         S_HI: begin
            if (in_deq__ENA) begin
               hi_d    = in_first;
               state_d = S_OUT;
            end else if (flush__ENA && flush__RDY) begin
               hi_d    = '0;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            // Dequeue here implies the packet leaves too; the new word starts the next pair.
            if (out_enq__ENA) begin
               if (in_deq__ENA) begin
                  lo_d    = in_first;
                  state_d = S_HI;
               end else begin
                  state_d = S_LO;
               end
            end
         end
         default: state_d = S_LO;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_LO;
         lo_q    <= '0;
         hi_q    <= '0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
      end
   end

`ifdef PONG_PACKER_COUNT_EN
   logic [COUNT_W-1:0] count_q, count_d;

   assign count_d   = out_enq__ENA ? count_q + 1'b1 : count_q;
   assign out_count = count_q;

   always_ff @(posedge CLK) begin
      if (RST) count_q <= '0;
      else     count_q <= count_d;
   end
`else
   if (COUNT_W == 0) begin : g_no_count
   end
`endif

endmodule
